sha256_round_ctrl: RTL and testbench

- Sequencing controller for the SHA-256 compression datapath.
- Accepts 512-bit block handshakes from the input staging stage and drives load, init, round-enable/index and hash-update strobes to the datapath.
- Tracks multi-block message boundaries and presents a digest-valid handshake to the consumer.
- Contains no data path; control only.

---
 rtl/sha256_round_ctrl_if.sv | 36 +++
 rtl/sha256_round_ctrl.sv | 99 +++++++++
 tb/tb_sha256_round_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_round_ctrl_if.sv
// Control bundle between the SHA-256 round controller, the input staging stage,
// the compression datapath and the digest consumer.
interface sha256_round_ctrl_if #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
);
  // Block handshake: a block transfers on a rising edge where in_valid && in_ready.
  // Digest handshake: the digest is taken on a rising edge where digest_valid && digest_ready.
  logic             in_valid;
  logic             first_block;
  logic             last_block;
  logic             in_ready;
  logic             abort;
  logic             load_block;
  logic             init_hash;
  logic             round_en;
  logic [IDX_W-1:0] round_idx;
  logic             update_hash;
  logic             digest_valid;
  logic             digest_ready;
  logic             busy;
  logic [CNT_W-1:0] blocks_done;
  logic [2:0]       dbg_state;

  modport master (
    input  in_valid, first_block, last_block, abort, digest_ready,
    output in_ready, load_block, init_hash, round_en, round_idx,
           update_hash, digest_valid, busy, blocks_done, dbg_state
  );

  modport slave (
    output in_valid, first_block, last_block, abort, digest_ready,
    input  in_ready, load_block, init_hash, round_en, round_idx,
           update_hash, digest_valid, busy, blocks_done, dbg_state
  );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: load, ROUNDS round cycles, hash update, and
// digest hand-off, with multi-block message chaining and synchronous abort.
module sha256_round_ctrl #(
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  sha256_round_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ROUND  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] round_idx_q;
  logic [CNT_W-1:0] blocks_done_q;
  logic             in_msg_q;
  logic             last_q;
  logic             init_q;
  logic             accept;

  // Abort wins over a same-cycle block offer, so ready is withheld while it is high.
  assign accept = (state_q == IDLE) && bus.in_valid && !bus.abort;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = ROUND;
      ROUND:   if (round_idx_q == LAST_IDX) state_d = UPDATE;
      UPDATE:  state_d = last_q ? DONE : IDLE;
      DONE:    if (bus.digest_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      round_idx_q   <= '0;
      blocks_done_q <= '0;
      in_msg_q      <= 1'b0;
      last_q        <= 1'b0;
      init_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.abort) begin
        in_msg_q    <= 1'b0;
        round_idx_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              last_q <= bus.last_block;
              // Outside a message every block starts from the initial constants.
              init_q <= bus.first_block || !in_msg_q;
            end
          end
          LOAD: begin
            in_msg_q    <= 1'b1;
            round_idx_q <= '0;
          end
          ROUND: begin
            if (round_idx_q == LAST_IDX) round_idx_q <= '0;
            else                         round_idx_q <= round_idx_q + IDX_W'(1);
          end
          UPDATE: begin
            blocks_done_q <= blocks_done_q + CNT_W'(1);
            if (last_q) in_msg_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready     = (state_q == IDLE) && !bus.abort;
  assign bus.load_block   = (state_q == LOAD);
  assign bus.init_hash    = (state_q == LOAD) && init_q;
  assign bus.round_en     = (state_q == ROUND);
  assign bus.round_idx    = round_idx_q;
  assign bus.update_hash  = (state_q == UPDATE) && !bus.abort;
  assign bus.digest_valid = (state_q == DONE) && !bus.abort;
  assign bus.busy         = (state_q != IDLE);
  assign bus.blocks_done  = blocks_done_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: default 64-round instance plus a
// 4-round, 2-bit-counter instance for the short-latency and wrap cases.
module tb_sha256_round_ctrl;

  localparam logic [31:0] S_IDLE   = 32'd0;
  localparam logic [31:0] S_LOAD   = 32'd1;
  localparam logic [31:0] S_ROUND  = 32'd2;
  localparam logic [31:0] S_UPDATE = 32'd3;
  localparam logic [31:0] S_DONE   = 32'd4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sha256_round_ctrl_if #(.IDX_W(6), .CNT_W(16)) m_if ();
  sha256_round_ctrl_if #(.IDX_W(2), .CNT_W(2))  s_if ();

  sha256_round_ctrl #(.ROUNDS(64), .IDX_W(6), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if.master)
  );

  sha256_round_ctrl #(.ROUNDS(4), .IDX_W(2), .CNT_W(2)) u_dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Offer one block to the 64-round instance and follow it through to idle/done.
  task automatic run_block(input logic first, input logic last,
                           input logic exp_init, input logic [31:0] exp_bd);
    m_if.in_valid    = 1'b1;
    m_if.first_block = first;
    m_if.last_block  = last;
    @(negedge clk);
    m_if.in_valid    = 1'b0;
    m_if.first_block = 1'b0;
    m_if.last_block  = 1'b0;
    chk("blk_load", m_if.load_block, 1);
    chk("blk_init", m_if.init_hash, exp_init);
    repeat (64) @(negedge clk);
    chk("blk_last_round_en", m_if.round_en, 1);
    chk("blk_last_round_idx", m_if.round_idx, 63);
    @(negedge clk);
    chk("blk_update", m_if.update_hash, 1);
    @(negedge clk);
    chk("blk_blocks_done", m_if.blocks_done, exp_bd);
    chk("blk_digest_valid", m_if.digest_valid, last);
    chk("blk_state", m_if.dbg_state, last ? S_DONE : S_IDLE);
    if (last) begin
      m_if.digest_ready = 1'b1;
      @(negedge clk);
      m_if.digest_ready = 1'b0;
      chk("blk_back_idle", m_if.dbg_state, S_IDLE);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    m_if.in_valid = 1'b0; m_if.first_block = 1'b0; m_if.last_block = 1'b0;
    m_if.abort    = 1'b0; m_if.digest_ready = 1'b0;
    s_if.in_valid = 1'b0; s_if.first_block = 1'b0; s_if.last_block = 1'b0;
    s_if.abort    = 1'b0; s_if.digest_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", m_if.in_ready, 1);
    chk("rst_busy", m_if.busy, 0);
    chk("rst_blocks_done", m_if.blocks_done, 0);
    chk("rst_round_idx", m_if.round_idx, 0);
    chk("rst_load", m_if.load_block, 0);
    chk("rst_round_en", m_if.round_en, 0);
    chk("rst_update", m_if.update_hash, 0);
    chk("rst_digest_valid", m_if.digest_valid, 0);
    chk("rst_state", m_if.dbg_state, S_IDLE);
    chk("rst_small_in_ready", s_if.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // single-block message with full latency trace
    m_if.in_valid = 1'b1; m_if.first_block = 1'b1; m_if.last_block = 1'b1;
    chk("t1_in_ready", m_if.in_ready, 1);
    @(negedge clk);
    m_if.in_valid = 1'b0; m_if.first_block = 1'b0; m_if.last_block = 1'b0;
    chk("t1_load", m_if.load_block, 1);
    chk("t1_init", m_if.init_hash, 1);
    chk("t1_in_ready_busy", m_if.in_ready, 0);
    chk("t1_busy", m_if.busy, 1);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("t1_round_en", m_if.round_en, 1);
      chk("t1_round_idx", m_if.round_idx, i);
      chk("t1_no_load", m_if.load_block, 0);
    end
    @(negedge clk);
    chk("t1_update", m_if.update_hash, 1);
    chk("t1_update_no_round", m_if.round_en, 0);
    chk("t1_update_idx", m_if.round_idx, 0);
    chk("t1_bd_before", m_if.blocks_done, 0);
    @(negedge clk);
    chk("t1_digest_valid", m_if.digest_valid, 1);
    chk("t1_no_update", m_if.update_hash, 0);
    chk("t1_blocks_done", m_if.blocks_done, 1);

    // consumer stalls 20 cycles while a new block is already offered
    m_if.in_valid = 1'b1; m_if.first_block = 1'b1; m_if.last_block = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("t4_digest_held", m_if.digest_valid, 1);
      chk("t4_in_ready_low", m_if.in_ready, 0);
      chk("t4_state_done", m_if.dbg_state, S_DONE);
    end
    m_if.digest_ready = 1'b1;
    m_if.in_valid = 1'b0; m_if.first_block = 1'b0; m_if.last_block = 1'b0;
    @(negedge clk);
    m_if.digest_ready = 1'b0;
    chk("t4_release_digest", m_if.digest_valid, 0);
    chk("t4_release_idle", m_if.dbg_state, S_IDLE);
    chk("t4_release_ready", m_if.in_ready, 1);
    chk("t4_release_busy", m_if.busy, 0);
    chk("t4_release_bd", m_if.blocks_done, 1);

    // digest_ready outside DONE is ignored
    m_if.digest_ready = 1'b1;
    @(negedge clk);
    m_if.digest_ready = 1'b0;
    chk("stray_ready_idle", m_if.dbg_state, S_IDLE);

    // two-block message, then in_msg=0 forcing init, then mid-message restart
    run_block(1'b1, 1'b0, 1'b1, 2);
    run_block(1'b0, 1'b1, 1'b0, 3);
    run_block(1'b0, 1'b1, 1'b1, 4);
    run_block(1'b1, 1'b0, 1'b1, 5);
    run_block(1'b1, 1'b1, 1'b1, 6);

    // abort at round_idx 30
    m_if.in_valid = 1'b1; m_if.first_block = 1'b1; m_if.last_block = 1'b0;
    @(negedge clk);
    m_if.in_valid = 1'b0; m_if.first_block = 1'b0;
    repeat (31) @(negedge clk);
    chk("t3_idx30", m_if.round_idx, 30);
    m_if.abort = 1'b1;
    #1;
    chk("t3_abort_ready", m_if.in_ready, 0);
    chk("t3_abort_no_update", m_if.update_hash, 0);
    @(negedge clk);
    m_if.abort = 1'b0;
    chk("t3_state_idle", m_if.dbg_state, S_IDLE);
    chk("t3_busy", m_if.busy, 0);
    chk("t3_idx_cleared", m_if.round_idx, 0);
    chk("t3_bd_unchanged", m_if.blocks_done, 6);
    chk("t3_no_digest", m_if.digest_valid, 0);
    run_block(1'b0, 1'b1, 1'b1, 7);

    // abort in IDLE blocks a same-cycle offer
    m_if.in_valid = 1'b1; m_if.abort = 1'b1;
    #1;
    chk("abort_idle_ready", m_if.in_ready, 0);
    @(negedge clk);
    chk("abort_idle_no_accept", m_if.dbg_state, S_IDLE);
    chk("abort_idle_no_load", m_if.load_block, 0);
    m_if.in_valid = 1'b0; m_if.abort = 1'b0;
    @(negedge clk);

    // asynchronous reset at round_idx 45
    m_if.in_valid = 1'b1; m_if.first_block = 1'b1; m_if.last_block = 1'b1;
    @(negedge clk);
    m_if.in_valid = 1'b0; m_if.first_block = 1'b0; m_if.last_block = 1'b0;
    repeat (46) @(negedge clk);
    chk("t5_idx45", m_if.round_idx, 45);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_state", m_if.dbg_state, S_IDLE);
    chk("t5_busy", m_if.busy, 0);
    chk("t5_round_en", m_if.round_en, 0);
    chk("t5_round_idx", m_if.round_idx, 0);
    chk("t5_blocks_done", m_if.blocks_done, 0);
    chk("t5_in_ready", m_if.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready_after", m_if.in_ready, 1);

    // 4-round instance: latency and 2-bit counter wrap
    for (int b = 0; b < 4; b++) begin
      s_if.in_valid = 1'b1; s_if.first_block = 1'b1; s_if.last_block = 1'b1;
      @(negedge clk);
      s_if.in_valid = 1'b0; s_if.first_block = 1'b0; s_if.last_block = 1'b0;
      chk("t6_load", s_if.load_block, 1);
      chk("t6_init", s_if.init_hash, 1);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("t6_round_en", s_if.round_en, 1);
        chk("t6_round_idx", s_if.round_idx, k);
      end
      @(negedge clk);
      chk("t6_update", s_if.update_hash, 1);
      @(negedge clk);
      chk("t6_digest_valid", s_if.digest_valid, 1);
      chk("t6_blocks_done", s_if.blocks_done, (b + 1) % 4);
      s_if.digest_ready = 1'b1;
      @(negedge clk);
      s_if.digest_ready = 1'b0;
      chk("t6_idle", s_if.dbg_state, S_IDLE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
